// File: rtl/ibex_rvfi_trace_fifo.sv
// ibex_rvfi_trace_fifo: RVFI retirement trace FIFO with gap marking and drop accounting.
// Define RVFI_TRACE_MEM_EN to also carry mem_addr/rmask/wmask per record.
module ibex_rvfi_trace_fifo #(
  parameter int Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [31:0]              rvfi_insn,
  input  logic [31:0]              rvfi_rd_wdata,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_intr,
`ifdef RVFI_TRACE_MEM_EN
  input  logic [31:0]              rvfi_mem_addr,
  input  logic [3:0]               rvfi_mem_rmask,
  input  logic [3:0]               rvfi_mem_wmask,
  output logic [31:0]              trace_mem_addr_o,
  output logic [3:0]               trace_mem_rmask_o,
  output logic [3:0]               trace_mem_wmask_o,
`endif
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_pc_o,
  output logic [31:0]              trace_insn_o,
  output logic [31:0]              trace_rd_wdata_o,
  output logic [4:0]               trace_rd_addr_o,
  output logic [15:0]              trace_order_o,
  output logic [2:0]               trace_flags_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     overflow_o,
  input  logic                     clear_i
);
  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FULL = (AW+1)'(Depth);
`ifdef RVFI_TRACE_MEM_EN
  localparam int RW = 160;
`else
  localparam int RW = 120;
`endif
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("ibex_rvfi_trace_fifo: Depth must be a power of two and at least 2");
  end
  logic [RW-1:0] r_mem [Depth];
  logic [RW-1:0] w_wdata;
  logic [RW-1:0] w_rdata;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [15:0]   r_drop_cnt;
  logic          r_overflow;
  logic          r_gap_pend;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_unused_order;
  assign w_unused_order = ^rvfi_order[63:16];
  assign w_pop  = (r_level != '0) & trace_ready_i;
  assign w_push = rvfi_valid & ((r_level != FULL) | w_pop);
  assign w_drop = rvfi_valid & ~w_push;
  assign w_wdata[119:0] = {r_gap_pend, rvfi_intr, rvfi_trap, rvfi_order[15:0], rvfi_rd_addr,
                           rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata};
  assign w_rdata = r_mem[r_rptr];
  assign {trace_flags_o, trace_order_o, trace_rd_addr_o, trace_rd_wdata_o, trace_insn_o,
          trace_pc_o} = w_rdata[119:0];
`ifdef RVFI_TRACE_MEM_EN
  assign w_wdata[159:120] = {rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask};
  assign {trace_mem_addr_o, trace_mem_rmask_o, trace_mem_wmask_o} = w_rdata[159:120];
`endif
  assign trace_valid_o = r_level != '0;
  assign level_o       = r_level;
  assign drop_cnt_o    = r_drop_cnt;
  assign overflow_o    = r_overflow;
  // Record storage is deliberately unreset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_wdata;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
      r_gap_pend <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level    <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_gap_pend <= w_drop | (r_gap_pend & ~w_push);
      r_overflow <= w_drop | (r_overflow & ~clear_i);
      r_drop_cnt <= clear_i ? {15'd0, w_drop}
                  : (w_drop && r_drop_cnt != 16'hFFFF) ? r_drop_cnt + 16'd1 : r_drop_cnt;
    end
  end
endmodule
